// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch FSM states and the PC increment helper.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic {
      FETCH  = 1'b0,
      HALTED = 1'b1
   } fetch_state_t;

   localparam word_t WORD_ZERO = 32'h0000_0000;

   // Wraps naturally modulo 2^32.
   function automatic word_t pc_plus4(input word_t pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Signal bundle for the fetch stage, with design-side and bench-side views.
interface fetch_stage_if (input logic CLK);
   import cpu_types_pkg::*;

   logic  nRST;
   logic  ihit;
   word_t imemload;
   logic  stall;
   logic  flush;
   logic  redirect;
   word_t redirect_pc;
   logic  halt;
   logic  imemREN;
   word_t imemaddr;
   word_t ifid_instr;
   word_t ifid_npc;
   logic  ifid_valid;

   modport fs (
      input  CLK, nRST, ihit, imemload, stall, flush, redirect, redirect_pc, halt,
      output imemREN, imemaddr, ifid_instr, ifid_npc, ifid_valid
   );

   modport tb (
      input  CLK, imemREN, imemaddr, ifid_instr, ifid_npc, ifid_valid,
      output nRST, ihit, imemload, stall, flush, redirect, redirect_pc, halt
   );

endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: flush loads a bubble, enable loads new contents, otherwise holds.
module ifid_reg
   import cpu_types_pkg::*;
(
   input  logic  CLK,
   input  logic  nRST,
   input  logic  en,
   input  logic  flush,
   input  word_t instr_in,
   input  word_t npc_in,
   input  logic  valid_in,
   output word_t instr,
   output word_t npc,
   output logic  valid
);

   word_t instr_q, instr_d;
   word_t npc_q, npc_d;
   logic  valid_q, valid_d;

   always_comb begin
      instr_d = instr_q;
      npc_d   = npc_q;
      valid_d = valid_q;
      if (flush) begin
         instr_d = WORD_ZERO;
         npc_d   = WORD_ZERO;
         valid_d = 1'b0;
      end else if (en) begin
         instr_d = instr_in;
         npc_d   = npc_in;
         valid_d = valid_in;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         instr_q <= WORD_ZERO;
         npc_q   <= WORD_ZERO;
         valid_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         npc_q   <= npc_d;
         valid_q <= valid_d;
      end
   end

   assign instr = instr_q;
   assign npc   = npc_q;
   assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, FETCH/HALTED control and the IF/ID register.
module fetch_stage
   import cpu_types_pkg::*;
#(
   parameter word_t PC_INIT = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ihit,
   input  logic [31:0] imemload,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic        imemREN,
   output logic [31:0] imemaddr,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_npc,
   output logic        ifid_valid
);

   fetch_state_t state_q, state_d;
   word_t        pc_q, pc_d;
   word_t        npc;
   logic         ifid_en;
   logic         ifid_clr;

   assign npc      = pc_plus4(pc_q);
   assign imemaddr = pc_q;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ifid_en  = 1'b0;
      ifid_clr = 1'b0;
      imemREN  = (state_q == FETCH);
      if (state_q == FETCH) begin
         if (halt) begin
            state_d  = HALTED;
            ifid_clr = 1'b1;
         end else if (redirect) begin
            // The word returned this cycle belongs to the wrong path.
            pc_d     = redirect_pc;
            ifid_clr = 1'b1;
         end else if (stall) begin
            ifid_clr = flush;
         end else if (ihit) begin
            pc_d     = npc;
            ifid_en  = 1'b1;
            ifid_clr = flush;
         end else begin
            ifid_clr = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= FETCH;
         pc_q    <= PC_INIT;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   ifid_reg u_ifid (
      .CLK      (CLK),
      .nRST     (nRST),
      .en       (ifid_en),
      .flush    (ifid_clr),
      .instr_in (imemload),
      .npc_in   (npc),
      .valid_in (1'b1),
      .instr    (ifid_instr),
      .npc      (ifid_npc),
      .valid    (ifid_valid)
   );

endmodule
